stage_if: RTL and testbench

- Instruction-fetch stage of the 5-stage RV32I pipeline; the producer of the pc/inst pair consumed by the decode stage.
- Maintains the fetch PC and issues word reads to instruction memory over a req/ack handshake.
- Buffers returned words in a small prefetch FIFO and presents them to decode, honouring downstream stall.
- Redirects and flushes on a taken branch/jump reported by later stages.

---
 rtl/stage_if.sv | 162 ++++++++++++++++
 tb/tb_stage_if.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_if.sv
// stage_if: instruction-fetch stage of the 5-stage RV32I pipeline.
// Holds the fetch PC and issues one word read at a time to instruction
// memory over a req/ack handshake. Returned words go into a small prefetch
// FIFO whose head is presented to decode. A taken branch/jump flushes the
// FIFO and redirects fetch.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   stall      decode cannot accept the presented instruction this cycle
//   br_taken   one-cycle redirect request from a later stage
//   br_target  redirect address (bits [1:0] forced to 0)
//   mem_req    read request, held with mem_addr until mem_ack
//   mem_addr   word-aligned read address
//   mem_ack    read data valid, completes the outstanding request
//   mem_rdata  instruction word, sampled only with mem_ack
//   id_valid   id_pc/id_inst carry a real instruction
//   id_pc      PC of the presented instruction (0 when not valid)
//   id_inst    presented instruction (NOP 32'h0000_0013 when not valid)
module stage_if #(
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst
);

  localparam int          PW  = $clog2(FIFO_DEPTH);
  localparam int          CW  = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} state_t;

  state_t          state_q, state_d;
  logic            mem_req_q, mem_req_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_after;
  logic [31:0]     fifo_pc_q   [FIFO_DEPTH];
  logic [31:0]     fifo_inst_q [FIFO_DEPTH];

  logic        push, pop, has_space;
  logic [31:0] tgt, next_pc;

  assign tgt     = br_target & ~32'h3;
  assign next_pc = mem_addr_q + 32'd4;   // wraps modulo 2^32

  assign id_valid = (cnt_q != '0);
  assign id_pc    = id_valid ? fifo_pc_q[rptr_q]   : 32'h0;
  assign id_inst  = id_valid ? fifo_inst_q[rptr_q] : NOP;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;

  // A redirect kills any same-cycle push (data is from the old path).
  assign pop  = id_valid && !stall;
  assign push = (state_q == S_REQ) && mem_ack && !br_taken;

  // Occupancy once this cycle's push/pop have taken effect; a new request
  // is only launched if its data is guaranteed a slot.
  assign cnt_after = cnt_q + CW'(push) - CW'(pop);
  assign has_space = cnt_after < CW'(FIFO_DEPTH);

  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    fetch_pc_d = fetch_pc_q;
    case (state_q)
      S_IDLE: begin
        if (br_taken) begin
          fetch_pc_d = tgt;
        end else if (has_space) begin
          state_d    = S_REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = fetch_pc_q;
        end
      end
      S_REQ: begin
        if (br_taken) begin
          fetch_pc_d = tgt;
          if (mem_ack) begin
            state_d   = S_IDLE;
            mem_req_d = 1'b0;
          end else begin
            // Request cannot be withdrawn: keep it up and discard its data.
            state_d = S_DROP;
          end
        end else if (mem_ack) begin
          fetch_pc_d = next_pc;
          if (has_space) begin
            mem_addr_d = next_pc;
          end else begin
            state_d   = S_IDLE;
            mem_req_d = 1'b0;
          end
        end
      end
      S_DROP: begin
        if (br_taken) fetch_pc_d = tgt;
        if (mem_ack) begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    wptr_d = wptr_q + PW'(push);
    rptr_d = rptr_q + PW'(pop);
    cnt_d  = cnt_after;
    if (br_taken) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      fetch_pc_q <= fetch_pc_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
    end
  end

  // FIFO payload needs no reset; occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      fifo_pc_q[wptr_q]   <= mem_addr_q;
      fifo_inst_q[wptr_q] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_stage_if.sv
module tb_stage_if;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] PAT = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst, stall, br_taken;
  logic [31:0] br_target;
  logic        mem_req, mem_ack;
  logic [31:0] mem_addr, mem_rdata;
  logic        id_valid;
  logic [31:0] id_pc, id_inst;

  // memory model: auto mode acks after wait_cfg extra cycles, manual mode
  // takes ack/data straight from the bench
  logic        man_mode, man_ack;
  logic [31:0] man_rdata;
  int          wait_cfg;
  int          wcnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stage_if #(.FIFO_DEPTH(2), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken),
    .br_target(br_target), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .id_valid(id_valid),
    .id_pc(id_pc), .id_inst(id_inst)
  );

  assign mem_ack   = man_mode ? man_ack : (mem_req && (wcnt >= wait_cfg));
  assign mem_rdata = man_mode ? man_rdata : (mem_addr ^ PAT);

  always @(posedge clk) begin
    if (!mem_req || mem_ack) wcnt <= 0;
    else                     wcnt <= wcnt + 1;
  end

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_v;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // leaves the bench at the negedge of the first cycle after reset release
  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = 32'h0;
    man_ack = 1'b0; man_rdata = 32'h0;
    step(); step();
    rst = 1'b0;
  endtask

  initial begin
    logic found;
    int   k;
    man_mode = 1'b1; wait_cfg = 0;

    // ---- table-driven, manual memory ----
    //           stall br tgt         ack rdata          req addr       v  pc          inst
    tbl[0]  = '{1'b0,1'b0,32'h0,  1'b0,32'h0,        1'b0,32'h0,   1'b0,32'h0,   NOP};
    tbl[1]  = '{1'b0,1'b0,32'h0,  1'b1,32'h1111_1111,1'b1,32'h0,   1'b0,32'h0,   NOP};
    tbl[2]  = '{1'b1,1'b0,32'h0,  1'b0,32'h0,        1'b1,32'h4,   1'b1,32'h0,   32'h1111_1111};
    tbl[3]  = '{1'b1,1'b0,32'h0,  1'b1,32'h2222_2222,1'b1,32'h4,   1'b1,32'h0,   32'h1111_1111};
    tbl[4]  = '{1'b1,1'b0,32'h0,  1'b1,32'h0,        1'b0,32'h4,   1'b1,32'h0,   32'h1111_1111};
    tbl[5]  = '{1'b0,1'b0,32'h0,  1'b0,32'h0,        1'b0,32'h4,   1'b1,32'h0,   32'h1111_1111};
    tbl[6]  = '{1'b0,1'b0,32'h0,  1'b1,32'h3333_3333,1'b1,32'h8,   1'b1,32'h4,   32'h2222_2222};
    tbl[7]  = '{1'b0,1'b1,32'h203,1'b0,32'h0,        1'b1,32'hC,   1'b1,32'h8,   32'h3333_3333};
    tbl[8]  = '{1'b0,1'b0,32'h0,  1'b0,32'h0,        1'b1,32'hC,   1'b0,32'h0,   NOP};
    tbl[9]  = '{1'b0,1'b1,32'h300,1'b0,32'h0,        1'b1,32'hC,   1'b0,32'h0,   NOP};
    tbl[10] = '{1'b0,1'b0,32'h0,  1'b1,32'h4444_4444,1'b1,32'hC,   1'b0,32'h0,   NOP};
    tbl[11] = '{1'b0,1'b0,32'h0,  1'b0,32'h0,        1'b0,32'hC,   1'b0,32'h0,   NOP};
    tbl[12] = '{1'b0,1'b1,32'h400,1'b1,32'h5555_5555,1'b1,32'h300, 1'b0,32'h0,   NOP};
    tbl[13] = '{1'b0,1'b0,32'h0,  1'b0,32'h0,        1'b0,32'h300, 1'b0,32'h0,   NOP};
    tbl[14] = '{1'b0,1'b0,32'h0,  1'b1,32'h6666_6666,1'b1,32'h400, 1'b0,32'h0,   NOP};
    tbl[15] = '{1'b0,1'b0,32'h0,  1'b0,32'h0,        1'b1,32'h404, 1'b1,32'h400, 32'h6666_6666};
    tbl[16] = '{1'b0,1'b0,32'h0,  1'b0,32'h0,        1'b1,32'h404, 1'b0,32'h0,   NOP};

    do_reset();
    for (int i = 0; i < 17; i++) begin
      stall = tbl[i].stall; br_taken = tbl[i].br; br_target = tbl[i].tgt;
      man_ack = tbl[i].ack; man_rdata = tbl[i].rdata;
      chk($sformatf("tbl%0d_req", i),  {31'b0, mem_req},  {31'b0, tbl[i].e_req});
      chk($sformatf("tbl%0d_addr", i), mem_addr,          tbl[i].e_addr);
      chk($sformatf("tbl%0d_vld", i),  {31'b0, id_valid}, {31'b0, tbl[i].e_v});
      chk($sformatf("tbl%0d_pc", i),   id_pc,             tbl[i].e_pc);
      chk($sformatf("tbl%0d_inst", i), id_inst,           tbl[i].e_inst);
      step();
    end
    br_taken = 1'b0; man_ack = 1'b0;

    // ---- zero-wait streaming, one instruction per cycle ----
    man_mode = 1'b0; wait_cfg = 0;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      if (c == 0) chk("stream_req_c0", {31'b0, mem_req}, 32'd0);
      if (c == 1) chk("stream_req_c1", {31'b0, mem_req}, 32'd1);
      if (c >= 2) begin
        chk($sformatf("stream_vld_c%0d", c), {31'b0, id_valid}, 32'd1);
        chk($sformatf("stream_pc_c%0d", c), id_pc, 32'(4 * (c - 2)));
        chk($sformatf("stream_inst_c%0d", c), id_inst, 32'(4 * (c - 2)) ^ PAT);
      end
      step();
    end

    // ---- stall 6 cycles at id_pc=8 ----
    do_reset();
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (id_valid && id_pc == 32'h8) found = 1'b1;
      else step();
    end
    chk("stall_find_pc8", {31'b0, found}, 32'd1);
    stall = 1'b1;
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("stall_pc_c%0d", c), id_pc, 32'h8);
      chk($sformatf("stall_vld_c%0d", c), {31'b0, id_valid}, 32'd1);
      step();
    end
    chk("stall_req_low", {31'b0, mem_req}, 32'd0);
    chk("stall_last_fetch", mem_addr, 32'hC);
    stall = 1'b0;
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("release_vld_%0d", j), {31'b0, id_valid}, 32'd1);
      chk($sformatf("release_pc_%0d", j), id_pc, 32'(8 + 4 * j));
      step();
    end

    // ---- 3-wait memory, redirect while request to 0x10 outstanding ----
    wait_cfg = 3;
    do_reset();
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (mem_req && mem_addr == 32'h10) found = 1'b1;
      else step();
    end
    chk("drop_find_req10", {31'b0, found}, 32'd1);
    br_taken = 1'b1; br_target = 32'h0000_0103;
    step();
    br_taken = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      chk($sformatf("drop_hold_req_c%0d", c), {31'b0, mem_req}, 32'd1);
      chk($sformatf("drop_hold_addr_c%0d", c), mem_addr, 32'h10);
      chk($sformatf("drop_novld_c%0d", c), {31'b0, id_valid}, 32'd0);
      if (mem_ack) found = 1'b1;
      step();
    end
    chk("drop_ack_seen", {31'b0, found}, 32'd1);
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      if (mem_req) found = 1'b1;
      else step();
    end
    chk("drop_new_req", {31'b0, found}, 32'd1);
    chk("drop_new_addr", mem_addr, 32'h100);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (id_valid) found = 1'b1;
      else step();
    end
    chk("drop_first_vld", {31'b0, found}, 32'd1);
    chk("drop_first_pc", id_pc, 32'h100);
    chk("drop_first_inst", id_inst, 32'h100 ^ PAT);

    // ---- redirect + ack + pop with full FIFO ----
    wait_cfg = 0;
    do_reset();
    stall = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (id_valid && !mem_req) found = 1'b1;
      else step();
    end
    chk("full_reached", {31'b0, found}, 32'd1);
    man_mode = 1'b1; man_ack = 1'b1; man_rdata = 32'hDEAD_BEEF;
    stall = 1'b0; br_taken = 1'b1; br_target = 32'h500;
    step();
    man_mode = 1'b0; man_ack = 1'b0; br_taken = 1'b0;
    chk("flush_vld", {31'b0, id_valid}, 32'd0);
    chk("flush_inst", id_inst, NOP);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (id_valid) found = 1'b1;
      else step();
    end
    chk("flush_first_vld", {31'b0, found}, 32'd1);
    chk("flush_first_pc", id_pc, 32'h500);

    // ---- reset mid-request, ack on the following cycle ----
    man_mode = 1'b1;
    do_reset();
    step();
    man_ack = 1'b1; man_rdata = 32'hAAAA_0001;
    step();
    man_rdata = 32'hAAAA_0002;
    step();
    man_ack = 1'b0;
    chk("rstmid_pre_addr", mem_addr, 32'h8);
    chk("rstmid_pre_pc", id_pc, 32'h4);
    rst = 1'b1;
    step();
    rst = 1'b0; man_ack = 1'b1; man_rdata = 32'h1234_5678;
    chk("rstmid_req", {31'b0, mem_req}, 32'd0);
    chk("rstmid_addr", mem_addr, 32'h0);
    chk("rstmid_vld", {31'b0, id_valid}, 32'd0);
    chk("rstmid_pc", id_pc, 32'h0);
    chk("rstmid_inst", id_inst, NOP);
    step();
    man_ack = 1'b0;
    chk("rstmid_ign_vld", {31'b0, id_valid}, 32'd0);
    chk("rstmid_restart_req", {31'b0, mem_req}, 32'd1);
    chk("rstmid_restart_addr", mem_addr, 32'h0);
    man_ack = 1'b1; man_rdata = 32'h0BAD_F00D;
    step();
    man_ack = 1'b0;
    chk("rstmid_after_pc", id_pc, 32'h0);
    chk("rstmid_after_inst", id_inst, 32'h0BAD_F00D);

    // ---- redirect latency and PC wrap ----
    man_mode = 1'b0; wait_cfg = 0;
    do_reset();
    step(); step(); step();
    k = 0;
    br_taken = 1'b1; br_target = 32'hFFFF_FFFF;
    step();
    br_taken = 1'b0;
    chk("redir_n1_vld", {31'b0, id_valid}, 32'd0);
    chk("redir_n1_req", {31'b0, mem_req}, 32'd0);
    step();
    chk("redir_n2_vld", {31'b0, id_valid}, 32'd0);
    chk("redir_n2_req", {31'b0, mem_req}, 32'd1);
    chk("redir_n2_addr", mem_addr, 32'hFFFF_FFFC);
    step();
    chk("redir_n3_vld", {31'b0, id_valid}, 32'd1);
    chk("redir_n3_pc", id_pc, 32'hFFFF_FFFC);
    chk("wrap_addr", mem_addr, 32'h0);
    step();
    chk("wrap_pc", id_pc, 32'h0);
    chk("wrap_inst", id_inst, PAT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
